adler32_chk: RTL and testbench

ADLER32_CHK -- requirements
Module: adler32_chk

---
 rtl/adler32_chk.sv | 96 +++++++++
 tb/tb_adler32_chk.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/adler32_chk.sv
// adler32_chk: byte-serial Adler-32 over a decompressed word stream, compared
// against the expected checksum taken from the zlib trailer.
module adler32_chk (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        val_i,
   input  logic [31:0] dat_i,
   input  logic [1:0]  num_i,
   input  logic        lst_i,
   input  logic        exp_val_i,
   input  logic [31:0] exp_dat_i,
   output logic        rdy_o,
   output logic [31:0] cks_o,
   output logic        done_o,
   output logic        ok_o,
   output logic        err_o
);
   typedef enum logic [2:0] {IDLE, ACTV, PROC, WEXP, CMP} state_t;
   state_t state, state_n;
   logic [15:0] s1_r, s2_r, s1_nx, s2_nx;
   logic [16:0] s1_sum, s2_sum, s1_red, s2_red;
   logic [31:0] exp_r, buf_r;
   logic [1:0]  cnt_r;
   logic        lst_r, exp_cap, acc, exp_take, exp_have;
   logic [7:0]  byte_in;
   assign rdy_o    = state == ACTV;
   assign acc      = val_i && rdy_o;
   assign cks_o    = {s2_r, s1_r};
   assign exp_take = exp_val_i && !exp_cap && (state == ACTV || state == PROC || state == WEXP);
   // a strobe landing with the final byte counts as already present
   assign exp_have = exp_cap || exp_take;
   assign byte_in  = state == PROC ? buf_r[31:24] : dat_i[31:24];
   assign s1_sum   = {1'b0, s1_r} + {9'b0, byte_in};
   assign s1_red   = s1_sum >= 17'd65521 ? s1_sum - 17'd65521 : s1_sum;
   assign s1_nx    = s1_red[15:0];
   assign s2_sum   = {1'b0, s2_r} + {1'b0, s1_nx};
   assign s2_red   = s2_sum >= 17'd65521 ? s2_sum - 17'd65521 : s2_sum;
   assign s2_nx    = s2_red[15:0];
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = start_i ? ACTV : IDLE;
         ACTV: if (acc) state_n = num_i != 2'd0 ? PROC : !lst_i ? ACTV : exp_have ? CMP : WEXP;
         PROC: if (cnt_r == 2'd1) state_n = !lst_r ? ACTV : exp_have ? CMP : WEXP;
         WEXP: state_n = exp_val_i ? CMP : WEXP;
         CMP:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         s1_r    <= '0;
         s2_r    <= '0;
         exp_r   <= '0;
         exp_cap <= 1'b0;
         buf_r   <= '0;
         cnt_r   <= '0;
         lst_r   <= 1'b0;
         done_o  <= 1'b0;
         ok_o    <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         done_o <= state == CMP;
         if (state == IDLE && start_i) begin
            s2_r    <= '0;
            s1_r    <= 16'd1;
            exp_cap <= 1'b0;
            ok_o    <= 1'b0;
            err_o   <= 1'b0;
         end
         if (acc || state == PROC) begin
            s1_r <= s1_nx;
            s2_r <= s2_nx;
         end
         if (acc) begin
            buf_r <= {dat_i[23:0], 8'h00};
            cnt_r <= num_i;
            lst_r <= lst_i;
         end else if (state == PROC) begin
            buf_r <= {buf_r[23:0], 8'h00};
            cnt_r <= cnt_r - 2'd1;
         end
         if (exp_take) begin
            exp_r   <= exp_dat_i;
            exp_cap <= 1'b1;
         end
         if (state == CMP) begin
            ok_o  <= cks_o == exp_r;
            err_o <= cks_o != exp_r;
         end
      end
endmodule

// File: tb/tb_adler32_chk.sv
// tb_adler32_chk: directed streams checked against a plain Adler-32 model and
// an expected-done-cycle computed from acceptance and strobe edges.
module tb_adler32_chk;
   logic        clk = 0, rst = 1, start_i = 0, val_i = 0, lst_i = 0, exp_val_i = 0;
   logic [31:0] dat_i = 0, exp_dat_i = 0;
   logic [1:0]  num_i = 0;
   logic        rdy_o, done_o, ok_o, err_o;
   logic [31:0] cks_o;
   int checks = 0, errors = 0, cyc = 0, done_due = -1, hits = 0;
   int last_edge, exp_edge, acc_edge, a1, a2, a3;
   bit last_known = 0, exp_seen = 0;
   logic [31:0] model_exp = 0, model_cks = 0, hold;
   byte unsigned q[$], lit[$];

   adler32_chk dut (
      .clk(clk), .rst(rst), .start_i(start_i), .val_i(val_i), .dat_i(dat_i),
      .num_i(num_i), .lst_i(lst_i), .exp_val_i(exp_val_i), .exp_dat_i(exp_dat_i),
      .rdy_o(rdy_o), .cks_o(cks_o), .done_o(done_o), .ok_o(ok_o), .err_o(err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h want %h at cycle %0d", n, a, e, cyc);
      end
   endtask

   function automatic logic [31:0] adler(input byte unsigned b[$]);
      int unsigned a = 1, s = 0;
      foreach (b[i]) begin
         a = (a + b[i]) % 65521;
         s = (s + a) % 65521;
      end
      return {s[15:0], a[15:0]};
   endfunction

   task automatic update_due();
      if (last_known && exp_seen) done_due = (last_edge > exp_edge ? last_edge : exp_edge) + 1;
   endtask

   task automatic do_start();
      start_i = 1;
      q.delete();
      exp_seen = 0;
      last_known = 0;
      done_due = -1;
      @(posedge clk); #1 start_i = 0;
   endtask

   task automatic note_exp(input logic [31:0] v, input int e);
      if (!exp_seen) begin
         exp_seen = 1;
         model_exp = v;
         exp_edge = e;
      end
      update_due();
   endtask

   task automatic strobe_exp(input logic [31:0] v);
      exp_val_i = 1;
      exp_dat_i = v;
      note_exp(v, cyc + 1);
      @(posedge clk); #1 exp_val_i = 0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic [1:0] n, input bit l);
      int t = 0;
      val_i = 1; dat_i = d; num_i = n; lst_i = l;
      do begin @(negedge clk); t++; end while (!rdy_o && t < 60);
      if (!rdy_o) begin
         checks++; errors++;
         $display("FAIL accept_timeout got rdy_o=0 want 1 within 60 cycles");
      end
      acc_edge = cyc + 1;
      for (int i = 0; i <= int'(n); i++) q.push_back(d[31-8*i -: 8]);
      if (l) begin
         last_known = 1;
         last_edge = acc_edge + int'(n);
         model_cks = adler(q);
         update_due();
      end
      @(posedge clk); #1 val_i = 0; lst_i = 0;
   endtask

   task automatic wait_done();
      int h = hits;
      for (int t = 0; t < 40 && hits == h; t++) begin @(negedge clk); #1; end
      checks++;
      if (hits == h) begin
         errors++;
         $display("FAIL done_missing got no done_o want one within 40 cycles");
      end
      @(posedge clk); #1;
   endtask

   // one compare process: done timing and results against the model
   always @(negedge clk) if (!rst) begin
      chk("ok_err_excl", ok_o & err_o, 0);
      if (done_o || cyc == done_due) begin
         chk("done_time", done_o, cyc == done_due);
         if (done_o) hits++;
         chk("cks_done", cks_o, model_cks);
         chk("ok_done", ok_o, model_cks == model_exp);
         chk("err_done", err_o, model_cks != model_exp);
      end
   end

   initial begin #100000; $display("FAIL global_timeout"); $fatal(1); end

   initial begin
      lit = '{8'h61, 8'h62, 8'h63};
      chk("model_abc", adler(lit), 32'h024D0127);
      lit = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
      chk("model_wiki", adler(lit), 32'h11E60398);
      repeat (2) @(posedge clk); #1;
      chk("rst_rdy", rdy_o, 0); chk("rst_cks", cks_o, 0); chk("rst_done", done_o, 0);
      chk("rst_ok", ok_o, 0); chk("rst_err", err_o, 0);
      rst = 0;
      // abc, expected given first; a second strobe must be ignored
      do_start();
      strobe_exp(32'h024D0127);
      strobe_exp(32'hDEADBEEF);
      send_word(32'h61626300, 2'd2, 1);
      wait_done();
      chk("abc_cks", cks_o, 32'h024D0127); chk("abc_ok", ok_o, 1);
      // Wikipedia with start pulses in PROC and WEXP, late expected
      do_start();
      send_word(32'h57696B69, 2'd3, 0); a1 = acc_edge;
      start_i = 1; @(posedge clk); #1 start_i = 0;
      send_word(32'h70656469, 2'd3, 0); a2 = acc_edge;
      send_word(32'h61000000, 2'd0, 1); a3 = acc_edge;
      chk("wiki_gap1", a2 - a1, 4); chk("wiki_gap2", a3 - a2, 4);
      repeat (4) @(posedge clk); #1;
      hold = cks_o;
      start_i = 1; @(posedge clk); #1 start_i = 0;
      chk("wexp_start_cks", cks_o, hold); chk("wexp_rdy", rdy_o, 0);
      chk("wiki_cks", cks_o, 32'h11E60398);
      strobe_exp(32'h11E60398);
      wait_done();
      chk("wiki_ok", ok_o, 1);
      // 257 bytes of 0xFF, wrong expected
      do_start();
      strobe_exp(32'h080F0010);
      repeat (64) send_word(32'hFFFFFFFF, 2'd3, 0);
      send_word(32'hFF000000, 2'd0, 1);
      wait_done();
      chk("wrap_cks", cks_o, 32'h080F000F); chk("wrap_err", err_o, 1); chk("wrap_ok", ok_o, 0);
      // single zero byte with expected on the same edge, stray strobe in CMP
      do_start();
      chk("start_clr_err", err_o, 0); chk("start_cks", cks_o, 32'h00000001);
      exp_val_i = 1; exp_dat_i = 32'h00010001;
      note_exp(32'h00010001, cyc + 1);
      send_word(32'h00000000, 2'd0, 1);
      exp_dat_i = 32'h0;
      @(posedge clk); #1 exp_val_i = 0;
      wait_done();
      chk("sim_ok", ok_o, 1); chk("sim_cks", cks_o, 32'h00010001);
      // reset mid-stream, then abc again
      do_start();
      send_word(32'h57696B69, 2'd3, 0);
      send_word(32'h70656469, 2'd3, 0);
      rst = 1; done_due = -1;
      @(posedge clk); #1 rst = 0;
      chk("mid_rst_cks", cks_o, 0); chk("mid_rst_rdy", rdy_o, 0);
      repeat (6) @(posedge clk); #1;
      do_start();
      strobe_exp(32'h024D0127);
      send_word(32'h61626300, 2'd2, 1);
      wait_done();
      chk("rst_abc_ok", ok_o, 1);
      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
